// File: rtl/ifm_buf_pkg.sv
// rtl/ifm_buf_pkg.sv - shared bank/reader encodings, default sizes and k*k fetch length for ifm_buffer_array
package ifm_buf_pkg;

   localparam int unsigned IFM_LANES = 8;
   localparam int unsigned IFM_PIX_W = 128;
   localparam int unsigned IFM_DEPTH = 64;

   typedef enum logic [1:0] {
      BANK_EMPTY   = 2'd0,
      BANK_FILLING = 2'd1,
      BANK_FULL    = 2'd2
   } bank_state_e;

   typedef enum logic [1:0] {
      RD_IDLE  = 2'd0,
      RD_FETCH = 2'd1,
      RD_LAST  = 2'd2
   } rd_state_e;

   // Largest window is 7*7 = 49, so 6 bits always hold the product.
   function automatic logic [5:0] kk_len(input logic [2:0] k);
      logic [5:0] k6;
      k6 = {3'b000, k};
      return k6 * k6;
   endfunction

endpackage

// File: rtl/ifm_lane_ram.sv
// rtl/ifm_lane_ram.sv - one pixel lane: 2*DEPTH x PIX_W simple dual-port RAM, address {bank,addr}, registered read
module ifm_lane_ram
   import ifm_buf_pkg::*;
#(
   parameter int unsigned PIX_W  = IFM_PIX_W,
   parameter int unsigned ADDR_W = $clog2(IFM_DEPTH)
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic              wr_en_i,
   input  logic [ADDR_W:0]   wr_addr_i,
   input  logic [PIX_W-1:0]  wr_data_i,
   input  logic              rd_en_i,
   input  logic [ADDR_W:0]   rd_addr_i,
   output logic [PIX_W-1:0]  rd_data_o
);

   logic [PIX_W-1:0] mem_q [2**(ADDR_W+1)];
   logic [PIX_W-1:0] rd_data_q;

   always_ff @(posedge clock) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Only the output register is reset; it also holds the last word between reads.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= '0;
      end else if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ifm_buffer_array.sv
// rtl/ifm_buffer_array.sv - LANES-wide ping-pong IFM buffer between im2col and cubic with shared bank control
// Define IFM_ZERO_PAD_EN to return zero words for read beats at or beyond the bank's valid count.
module ifm_buffer_array
   import ifm_buf_pkg::*;
#(
   parameter int unsigned LANES  = IFM_LANES,
   parameter int unsigned PIX_W  = IFM_PIX_W,
   parameter int unsigned DEPTH  = IFM_DEPTH,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic                    clock,
   input  logic                    rst_n,
   input  logic [2:0]              ksize,
   input  logic [LANES-1:0]        ifm_wr_en,
   input  logic [LANES*ADDR_W-1:0] ifm_wr_addr,
   input  logic                    i2c_ready,
   input  logic                    i2c_done,
   input  logic [LANES*PIX_W-1:0]  pixels_in,
   input  logic [ADDR_W:0]         valid_num,
   output logic                    buf_empty,
   output logic                    buf_full,
   input  logic                    cubic_fetch_en,
   input  logic [ADDR_W:0]         fetch_num,
   output logic                    fetch_valid,
   output logic                    fetch_done,
   output logic [LANES*PIX_W-1:0]  pixels_to_cubic
);

   localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

   bank_state_e       bank_q [2];
   bank_state_e       bank_d [2];
   logic [ADDR_W:0]   cnt_q [2];
   logic [ADDR_W:0]   cnt_d [2];
   logic              wr_bank_q, wr_bank_d;
   logic              rd_bank_q, rd_bank_d;
   rd_state_e         rd_state_q, rd_state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic              valid_q, done_q;
   logic              rd_issue, rd_last, wr_open;
   logic [ADDR_W:0]   req_len;
   logic [LANES*PIX_W-1:0] ram_rd_data;

   assign wr_open   = (bank_q[wr_bank_q] == BANK_FILLING);
   assign buf_full  = (bank_q[wr_bank_q] == BANK_FULL);
   assign buf_empty = (bank_q[0] == BANK_EMPTY) && (bank_q[1] == BANK_EMPTY);
   assign rd_issue  = (rd_state_q == RD_FETCH);
   assign rd_last   = ({1'b0, addr_q} == len_q - (ADDR_W+1)'(1));

   always_comb begin
      req_len = (fetch_num == '0) ? (ADDR_W+1)'(kk_len(ksize)) : fetch_num;
      if (req_len > DEPTH_W) begin
         req_len = DEPTH_W;
      end
   end

   always_comb begin
      bank_d     = bank_q;
      cnt_d      = cnt_q;
      wr_bank_d  = wr_bank_q;
      rd_bank_d  = rd_bank_q;
      rd_state_d = rd_state_q;
      addr_d     = addr_q;
      len_d      = len_q;

      if (i2c_ready && (bank_q[wr_bank_q] == BANK_EMPTY)) begin
         bank_d[wr_bank_q] = BANK_FILLING;
      end
      if (i2c_done && !buf_full) begin
         cnt_d[wr_bank_q]  = valid_num;
         bank_d[wr_bank_q] = BANK_FULL;
         if (bank_q[~wr_bank_q] == BANK_EMPTY) begin
            wr_bank_d = ~wr_bank_q;
         end
      end else if (buf_full && (bank_q[~wr_bank_q] == BANK_EMPTY)) begin
         // Other bank was freed in the same cycle as our commit; move over now.
         wr_bank_d = ~wr_bank_q;
      end

      case (rd_state_q)
         RD_IDLE: begin
            if (cubic_fetch_en && (bank_q[rd_bank_q] == BANK_FULL) && (req_len != '0)) begin
               len_d      = req_len;
               addr_d     = '0;
               rd_state_d = RD_FETCH;
            end
         end
         RD_FETCH: begin
            if (rd_last) begin
               rd_state_d = RD_LAST;
            end else begin
               addr_d = addr_q + ADDR_W'(1);
            end
         end
         RD_LAST: begin
            bank_d[rd_bank_q] = BANK_EMPTY;
            rd_bank_d         = ~rd_bank_q;
            rd_state_d        = RD_IDLE;
            if (buf_full) begin
               wr_bank_d = rd_bank_q;
            end
         end
         default: rd_state_d = RD_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         bank_q[0]  <= BANK_EMPTY;
         bank_q[1]  <= BANK_EMPTY;
         cnt_q[0]   <= '0;
         cnt_q[1]   <= '0;
         wr_bank_q  <= 1'b0;
         rd_bank_q  <= 1'b0;
         rd_state_q <= RD_IDLE;
         addr_q     <= '0;
         len_q      <= '0;
         valid_q    <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         bank_q     <= bank_d;
         cnt_q      <= cnt_d;
         wr_bank_q  <= wr_bank_d;
         rd_bank_q  <= rd_bank_d;
         rd_state_q <= rd_state_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         valid_q    <= rd_issue;
         done_q     <= rd_issue && rd_last;
      end
   end

   assign fetch_valid = valid_q;
   assign fetch_done  = done_q;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      ifm_lane_ram #(
         .PIX_W  (PIX_W),
         .ADDR_W (ADDR_W)
      ) u_ram (
         .clock     (clock),
         .rst_n     (rst_n),
         .wr_en_i   (ifm_wr_en[i] && wr_open),
         .wr_addr_i ({wr_bank_q, ifm_wr_addr[i*ADDR_W +: ADDR_W]}),
         .wr_data_i (pixels_in[i*PIX_W +: PIX_W]),
         .rd_en_i   (rd_issue),
         .rd_addr_i ({rd_bank_q, addr_q}),
         .rd_data_o (ram_rd_data[i*PIX_W +: PIX_W])
      );
   end

`ifdef IFM_ZERO_PAD_EN
   logic pad_q;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         pad_q <= 1'b0;
      end else if (rd_issue) begin
         pad_q <= ({1'b0, addr_q} >= cnt_q[rd_bank_q]);
      end
   end

   assign pixels_to_cubic = pad_q ? '0 : ram_rd_data;
`else
   logic unused_cnt;
   assign unused_cnt      = ^{cnt_q[0], cnt_q[1]};
   assign pixels_to_cubic = ram_rd_data;
`endif

endmodule
